// File: rtl/life_stream_gen.sv
// rtl/life_stream_gen.sv - raster scanner of the life playfield RAM driving the scaler pixel stream
// Optional LIFE_STREAM_TESTPAT_EN replaces RAM data with a checkerboard of identical timing.
module life_stream_gen #(
  parameter int H_LIFE  = 1600,
  parameter int V_LIFE  = 1200,
  parameter int H_BLANK = 16,
  parameter int V_BLANK = 4,
  parameter int AW      = 20,
  parameter int D_LAG   = 3
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          run,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [1:0]    mem_dout,
  output logic [1:0]    life_d,
  output logic          life_active,
  output logic [11:0]   life_h_counter,
  output logic [10:0]   life_v_counter,
  output logic          frame_done
);
  localparam int HP   = H_LIFE / 2;
  localparam int LINE = HP + H_BLANK;
  localparam int VTOT = V_LIFE + V_BLANK;
  localparam int XD   = (D_LAG > 3) ? D_LAG - 3 : 0;
  localparam logic [11:0] H_LAST   = 12'(2 * LINE - 2);
  localparam logic [10:0] V_LAST   = 11'(VTOT - 1);
  localparam logic [11:0] H_LIFE_C = 12'(H_LIFE);
  localparam logic [10:0] V_LIFE_C = 11'(V_LIFE);
  localparam logic [10:0] RJ_LAST  = 11'(HP + 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q, state_d;
  logic [11:0]   h_q, h_d;
  logic [10:0]   v_q, v_d;
  logic          at_end;
  logic [11:0]   rh;
  logic [10:0]   rv, rj;
  logic [AW-1:0] pair, mem_addr_d, mem_addr_q;
  logic          mem_rd_d, mem_rd_q, rd_v_q;
  logic          frame_done_d, frame_done_q, active_d, active_q;
  logic [1:0]    data_in;
  logic [1:0]    dpipe_q [0:XD];

  function automatic logic [11:0] adv_h(input logic [11:0] h);
    return (h == H_LAST) ? 12'd0 : h + 12'd2;
  endfunction

  function automatic logic [10:0] adv_v(input logic [11:0] h, input logic [10:0] v);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? 11'd0 : v + 11'd1;
  endfunction

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= H_LAST;
      v_q     <= V_LAST;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // IDLE always sits on the frame-end position, so starting is just the normal wrap to (0,0)
  always_comb begin
    at_end  = (h_q == H_LAST) && (v_q == V_LAST);
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (at_end) state_d = run ? SCAN : IDLE;
    if (!at_end || run) begin
      h_d = adv_h(h_q);
      v_d = adv_v(h_q, v_q);
    end
  end

  // Read slot rj: 0 = pre-read, 1..HP = pairs, HP+1 = post-read; D_LAG=2 needs one step of lookahead
  always_comb begin
    rh = h_d;
    rv = v_d;
    if (D_LAG == 2 && state_d == SCAN && !(h_d == H_LAST && v_d == V_LAST && !run)) begin
      rh = adv_h(h_d);
      rv = adv_v(h_d, v_d);
    end
    rj   = 11'(rh >> 1);
    pair = (rj == 11'd0) ? AW'(HP - 1) : ((rj == RJ_LAST) ? '0 : AW'(rj) - AW'(1));
    mem_rd_d     = (state_d == SCAN) && (rv < V_LIFE_C) && (rj <= RJ_LAST);
    mem_addr_d   = mem_rd_d ? (AW'(rv) * AW'(HP) + pair) : '0;
    frame_done_d = (state_d == SCAN) && (h_d == H_LAST) && (v_d == V_LAST);
    active_d     = (h_d < H_LIFE_C) && (v_d < V_LIFE_C);
  end

`ifdef LIFE_STREAM_TESTPAT_EN
  logic tp_q, tp2_q;
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      tp_q  <= 1'b0;
      tp2_q <= 1'b0;
    end else begin
      tp_q  <= rv[0] ^ pair[0];
      tp2_q <= tp_q;
    end
  end
  assign data_in = {tp2_q, ~tp2_q};
`else
  assign data_in = mem_dout;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      rd_v_q       <= 1'b0;
      frame_done_q <= 1'b0;
      active_q     <= 1'b0;
      for (int i = 0; i <= XD; i++) dpipe_q[i] <= 2'b00;
    end else begin
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      rd_v_q       <= mem_rd_q;
      frame_done_q <= frame_done_d;
      active_q     <= active_d;
      dpipe_q[0]   <= rd_v_q ? data_in : 2'b00;
      for (int i = 1; i <= XD; i++) dpipe_q[i] <= dpipe_q[i-1];
    end
  end

  assign mem_rd         = mem_rd_q;
  assign mem_addr       = mem_addr_q;
  assign life_d         = dpipe_q[XD];
  assign life_active    = active_q;
  assign life_h_counter = h_q;
  assign life_v_counter = v_q;
  assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_life_stream_gen.sv
// tb/tb_life_stream_gen.sv - randomized run/reset stimulus checked against a frame-index reference model
module tb_life_stream_gen;
  localparam int H_LIFE = 8, V_LIFE = 4, H_BLANK = 4, V_BLANK = 2, AW = 20, D_LAG = 3;
  localparam int HP = H_LIFE / 2, LINE = HP + H_BLANK, VTOT = V_LIFE + V_BLANK;
  localparam int FRAME = LINE * VTOT;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0, run = 1'b0;
  logic          mem_rd, life_active, frame_done;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_dout = 2'b00, life_d;
  logic [11:0]   life_h_counter;
  logic [10:0]   life_v_counter;

  int n_checks = 0, n_fail = 0;

  logic [1:0] ram [HP*V_LIFE];
  logic [1:0] exp_d [int];
  int         exp_rd [int];
  bit         m_scan = 1'b0;
  int         m_n = FRAME - 1;
  bit         prev_rd = 1'b0;
  int         prev_addr = 0;
  int         stage = 0, idle_cnt = 0, hold = 0;

  always #5 clk_in = ~clk_in;

  life_stream_gen #(.H_LIFE(H_LIFE), .V_LIFE(V_LIFE), .H_BLANK(H_BLANK), .V_BLANK(V_BLANK),
                    .AW(AW), .D_LAG(D_LAG)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .run(run), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .life_d(life_d), .life_active(life_active),
    .life_h_counter(life_h_counter), .life_v_counter(life_v_counter), .frame_done(frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pixel_pair(input int r, input int k);
`ifdef LIFE_STREAM_TESTPAT_EN
    logic b;
    b = 1'(r) ^ 1'(k);
    return {b, ~b};
`else
    return ram[r*HP + k];
`endif
  endfunction

  initial begin
    int h_e, v_e, k;
    for (int i = 0; i < HP*V_LIFE; i++) ram[i] = 2'($urandom);
    for (int cyc = 0; cyc < 2400; cyc++) begin
      @(negedge clk_in);
      mem_dout = (prev_rd && prev_addr < HP*V_LIFE) ? ram[prev_addr] : 2'($urandom);
      h_e = 2 * (m_n % LINE);
      v_e = m_n / LINE;
      // a whole row of reads and its data timeline is scheduled when the row starts
      if (m_scan && h_e == 0 && v_e < V_LIFE) begin
        for (int i = 0; i <= HP + 1; i++) begin
          k = (i == 0) ? HP - 1 : ((i == HP + 1) ? 0 : i - 1);
          exp_rd[cyc + D_LAG - 3 + i] = v_e * HP + k;
          exp_d[cyc + D_LAG - 1 + i]  = pixel_pair(v_e, k);
        end
      end
      check_eq("h_counter", 32'(life_h_counter), h_e);
      check_eq("v_counter", 32'(life_v_counter), v_e);
      check_eq("active", 32'(life_active), 32'(h_e < H_LIFE && v_e < V_LIFE));
      check_eq("frame_done", 32'(frame_done), 32'(m_scan && m_n == FRAME - 1));
      check_eq("mem_rd", 32'(mem_rd), 32'(exp_rd.exists(cyc)));
      if (exp_rd.exists(cyc)) check_eq("mem_addr", 32'(mem_addr), exp_rd[cyc]);
      check_eq("life_d", 32'(life_d), exp_d.exists(cyc) ? 32'(exp_d[cyc]) : 32'd0);
      prev_rd   = mem_rd;
      prev_addr = int'(mem_addr);
      if (exp_rd.exists(cyc)) exp_rd.delete(cyc);
      if (exp_d.exists(cyc)) exp_d.delete(cyc);

      rst_n = 1'b1;
      case (stage)
        0: begin
          run = 1'b1;
          if (cyc >= 110) stage = 1;
        end
        1: if (m_scan && v_e == 2) begin
          run = 1'b0;
          stage = 2;
        end
        2: begin
          if (!m_scan) idle_cnt++;
          if (idle_cnt == 8) begin
            run = 1'b1;
            stage = 3;
          end
        end
        3: if (m_scan && m_n == LINE + 3) begin
          rst_n = 1'b0;
          stage = 4;
        end
        default: begin
          if (hold == 0) begin
            run  = ($urandom_range(0, 3) != 0);
            hold = $urandom_range(5, 80);
          end else hold--;
          if ($urandom_range(0, 249) == 0) rst_n = 1'b0;
        end
      endcase

      if (!rst_n) begin
        m_scan = 1'b0;
        m_n    = FRAME - 1;
        exp_rd.delete();
        exp_d.delete();
      end else if (m_n == FRAME - 1) begin
        m_scan = run;
        m_n    = run ? 0 : FRAME - 1;
      end else begin
        m_n++;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
